// File: rtl/edge_scan_ctrl.sv
// edge_scan_ctrl: scan controller for the Sobel edge-detection accelerator.
// Walks the source image one word column at a time. For each column it reads the
// 3-row window, hands it to the datapath and writes the result word back to the
// destination image.
// Optional build macro EDGE_SCAN_BORDER_EN: zero-fill destination rows 0 and ROWS-1
// before the scan starts.
module edge_scan_ctrl #(
    parameter int unsigned WORDS_PER_ROW = 88,
    parameter int unsigned ROWS          = 288,
    parameter int unsigned DST_BASE      = 25344
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        finish,
    output logic [15:0] addr,
    input  logic [31:0] dataR,
    output logic [31:0] dataW,
    output logic        en,
    output logic        we,
    output logic [31:0] win_top,
    output logic [31:0] win_mid,
    output logic [31:0] win_bot,
    output logic        win_first,
    output logic        win_last,
    output logic        win_valid,
    input  logic        res_valid,
    input  logic [31:0] res_data
);

    localparam logic [15:0] Wpr     = 16'(WORDS_PER_ROW);
    localparam logic [15:0] Wpr2    = 16'(2 * WORDS_PER_ROW);
    localparam logic [15:0] XLast   = 16'(WORDS_PER_ROW - 1);
    localparam logic [15:0] YLast   = 16'(ROWS - 2);
    // base_q addresses source row y-1, so destination row y sits one row further on
    localparam logic [15:0] DstMid  = 16'(DST_BASE + WORDS_PER_ROW);
`ifdef EDGE_SCAN_BORDER_EN
    localparam logic [15:0] DstBase = 16'(DST_BASE);
    localparam logic [15:0] DstLast = 16'(DST_BASE + (ROWS - 1) * WORDS_PER_ROW);
`endif

    typedef enum logic [3:0] {
        StIdle, StBorder, StRdT, StRdM, StRdB, StWin, StWait, StWr, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] base_q, base_d;
    logic [31:0] rtop_q, rtop_d;
    logic [31:0] rmid_q, rmid_d;
    logic [31:0] top_q, top_d;
    logic [31:0] mid_q, mid_d;
    logic [31:0] bot_q, bot_d;
    logic        first_q, first_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;
    logic [31:0] res_q, res_d;
`ifdef EDGE_SCAN_BORDER_EN
    logic        hi_q, hi_d;
`endif

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= '0;
            rtop_q  <= '0;
            rmid_q  <= '0;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= '0;
`ifdef EDGE_SCAN_BORDER_EN
            hi_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            rtop_q  <= rtop_d;
            rmid_q  <= rmid_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
            first_q <= first_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            res_q   <= res_d;
`ifdef EDGE_SCAN_BORDER_EN
            hi_q    <= hi_d;
`endif
        end
    end

    // Next-state logic and memory port outputs
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        rtop_d  = rtop_q;
        rmid_d  = rmid_q;
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        first_d = first_q;
        last_d  = last_q;
        valid_d = 1'b0;
        res_d   = res_q;
`ifdef EDGE_SCAN_BORDER_EN
        hi_d    = hi_q;
`endif
        en      = 1'b0;
        we      = 1'b0;
        addr    = '0;
        dataW   = res_q;
        finish  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    x_d    = '0;
                    y_d    = 16'd1;
                    base_d = '0;
`ifdef EDGE_SCAN_BORDER_EN
                    hi_d    = 1'b0;
                    state_d = StBorder;
`else
                    state_d = StRdT;
`endif
                end
            end
`ifdef EDGE_SCAN_BORDER_EN
            StBorder: begin
                en    = 1'b1;
                we    = 1'b1;
                dataW = '0;
                addr  = (hi_q ? DstLast : DstBase) + x_q;
                if (x_q == XLast) begin
                    x_d  = '0;
                    hi_d = 1'b1;
                    if (hi_q) state_d = StRdT;
                end else begin
                    x_d = x_q + 16'd1;
                end
            end
`endif
            StRdT: begin
                en      = 1'b1;
                addr    = base_q + x_q;
                state_d = StRdM;
            end
            StRdM: begin
                en      = 1'b1;
                addr    = base_q + Wpr + x_q;
                rtop_d  = dataR;
                state_d = StRdB;
            end
            StRdB: begin
                en      = 1'b1;
                addr    = base_q + Wpr2 + x_q;
                rmid_d  = dataR;
                state_d = StWin;
            end
            StWin: begin
                // Publish the whole window at once so it stays stable until the next strobe
                top_d   = rtop_q;
                mid_d   = rmid_q;
                bot_d   = dataR;
                first_d = (x_q == 16'd0);
                last_d  = (x_q == XLast);
                valid_d = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (res_valid) begin
                    res_d   = res_data;
                    state_d = StWr;
                end
            end
            StWr: begin
                en    = 1'b1;
                we    = 1'b1;
                addr  = DstMid + base_q + x_q;
                dataW = res_q;
                if (x_q == XLast) begin
                    x_d    = '0;
                    y_d    = y_q + 16'd1;
                    base_d = base_q + Wpr;
                    state_d = (y_q == YLast) ? StDone : StRdT;
                end else begin
                    x_d     = x_q + 16'd1;
                    state_d = StRdT;
                end
            end
            StDone: begin
                finish = 1'b1;
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign win_top   = top_q;
    assign win_mid   = mid_q;
    assign win_bot   = bot_q;
    assign win_first = first_q;
    assign win_last  = last_q;
    assign win_valid = valid_q;

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Self-checking bench for edge_scan_ctrl on a reduced 32x6 image (8 words per row).
module tb_edge_scan_ctrl;

    localparam int W     = 8;
    localparam int R     = 6;
    localparam int DB    = 48;
    localparam int NWIN  = (R - 2) * W;
    localparam int MEMSZ = 128;
    localparam int BUDGET = 3000;
`ifdef EDGE_SCAN_BORDER_EN
    localparam int Border = 1;
`else
    localparam int Border = 0;
`endif

    logic        clk, reset, start, finish, en, we;
    logic [15:0] addr;
    logic [31:0] dataR, dataW, win_top, win_mid, win_bot, res_data;
    logic        win_first, win_last, win_valid, res_valid;

    edge_scan_ctrl #(.WORDS_PER_ROW(W), .ROWS(R), .DST_BASE(DB)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish), .addr(addr),
        .dataR(dataR), .dataW(dataW), .en(en), .we(we), .win_top(win_top),
        .win_mid(win_mid), .win_bot(win_bot), .win_first(win_first), .win_last(win_last),
        .win_valid(win_valid), .res_valid(res_valid), .res_data(res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f(input logic [31:0] t, input logic [31:0] m,
                                      input logic [31:0] b);
        return {m[15:0], m[31:16]} ^ (t + 32'h1234_5678) ^ ~b;
    endfunction

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } acc_t;

    logic [31:0] mem [MEMSZ];
    logic [31:0] img [W*R];
    acc_t        log_q[$];

    // Memory model: one-cycle read latency, every access logged
    initial begin
        dataR = '0;
        forever begin
            @(posedge clk);
            if (en) begin
                log_q.push_back({we, addr, we ? dataW : 32'd0});
                if (we) mem[addr[6:0]] = dataW;
                else dataR <= mem[addr[6:0]];
            end
        end
    end

    // Datapath responder configuration and bookkeeping
    int   cfg_dly;     // -1: random delay per window
    int   cfg_dmax;
    int   cfg_spur;    // 0 quiet, 1 random pulses, 2 res_valid held high
    int   win_k;
    int   dly_sum;
    int   target_k;
    bit   target_hit;

    initial begin
        logic [31:0] st, sm, sb;
        logic        sf, sl;
        bit          pending;
        int          cnt, yy, xx, d;
        pending = 0; cnt = 0;
        res_valid = 1'b0;
        res_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending   = 0;
                res_valid = 1'b0;
            end else begin
                if (win_valid) begin
                    if (win_k < NWIN) begin
                        yy = 1 + win_k / W;
                        xx = win_k % W;
                        check("win_top", win_top, img[(yy-1)*W+xx]);
                        check("win_mid", win_mid, img[yy*W+xx]);
                        check("win_bot", win_bot, img[(yy+1)*W+xx]);
                        check("win_first_last", {win_first, win_last},
                              {xx == 0, xx == W - 1});
                    end else begin
                        check("extra_window", win_k, NWIN - 1);
                    end
                    if (win_k == target_k) target_hit = 1;
                    st = win_top; sm = win_mid; sb = win_bot; sf = win_first; sl = win_last;
                    d = (cfg_dly < 0) ? int'($urandom_range(cfg_dmax, 0)) : cfg_dly;
                    dly_sum += d;
                    cnt = d;
                    pending = 1;
                    win_k++;
                end else if (pending) begin
                    check("win_stable_tm", {win_top, win_mid}, {st, sm});
                    check("win_stable_b", {win_valid, win_first, win_last, win_bot},
                          {1'b0, sf, sl, sb});
                end
                if (pending) begin
                    if (cnt == 0) begin
                        res_valid = 1'b1;
                        res_data  = f(st, sm, sb);
                        pending   = 0;
                    end else begin
                        cnt--;
                        res_valid = 1'b0;
                        res_data  = $urandom;
                    end
                end else begin
                    res_valid = (cfg_spur == 2) ? 1'b1 :
                                (cfg_spur == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
                    res_data  = $urandom;
                end
            end
        end
    end

    typedef struct {
        string name;
        int    pattern;   // 0: word k holds k, 1: random image
        int    dly;
        int    dmax;
        int    spur;
        int    exp_writes;
        int    exp_last_wr;
    } scen_t;

    task automatic setup(input scen_t s);
        for (int i = 0; i < MEMSZ; i++) begin
            if (i < W * R) begin
                mem[i] = (s.pattern == 0) ? 32'(i) : $urandom;
                img[i] = mem[i];
            end else begin
                mem[i] = 32'hFFFF_FFFF;
            end
        end
        log_q.delete();
        win_k = 0; dly_sum = 0; target_hit = 0; target_k = -1;
        cfg_dly = s.dly; cfg_dmax = s.dmax; cfg_spur = s.spur;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {finish, en, we, win_first, win_last, win_valid}, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_dataW"}, dataW, 0);
        check({tag, "_win_tm"}, {win_top, win_mid}, 0);
        check({tag, "_win_b"}, win_bot, 0);
    endtask

    task automatic run_scan(input scen_t s);
        acc_t exp_q[$];
        int   cyc, nwr;
        bit   done;
        setup(s);
        @(negedge clk);
        start = 1'b1;
        cyc = 0; done = 0;
        while (cyc < BUDGET && !done) begin
            @(posedge clk);
            cyc++;
            #1 done = finish;
        end
        check({s.name, "_finish_cycle"}, cyc, 1 + Border * 2 * W + 6 * NWIN + dly_sum);
        @(posedge clk);
        #1 check({s.name, "_done_hold"}, finish, 1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 check({s.name, "_finish_drop"}, {finish, en}, 0);
        check({s.name, "_windows"}, win_k, NWIN);

        if (Border != 0) begin
            for (int x = 0; x < W; x++) exp_q.push_back({1'b1, 16'(DB + x), 32'd0});
            for (int x = 0; x < W; x++) exp_q.push_back({1'b1, 16'(DB + (R-1)*W + x), 32'd0});
        end
        for (int y = 1; y <= R - 2; y++) begin
            for (int x = 0; x < W; x++) begin
                exp_q.push_back({1'b0, 16'((y-1)*W + x), 32'd0});
                exp_q.push_back({1'b0, 16'(y*W + x), 32'd0});
                exp_q.push_back({1'b0, 16'((y+1)*W + x), 32'd0});
                exp_q.push_back({1'b1, 16'(DB + y*W + x),
                                 f(img[(y-1)*W+x], img[y*W+x], img[(y+1)*W+x])});
            end
        end
        check({s.name, "_n_access"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check({s.name, "_access"}, log_q[i], exp_q[i]);
        nwr = 0;
        foreach (log_q[i]) if (log_q[i].we) nwr++;
        check({s.name, "_n_writes"}, nwr, s.exp_writes);
        if (log_q.size() > 0)
            check({s.name, "_last_wr_addr"}, log_q[log_q.size()-1].addr, s.exp_last_wr);
        for (int x = 0; x < W; x++) begin
            check({s.name, "_dst_row0"}, mem[DB + x], (Border != 0) ? 32'd0 : 32'hFFFF_FFFF);
            check({s.name, "_dst_rowN"}, mem[DB + (R-1)*W + x],
                  (Border != 0) ? 32'd0 : 32'hFFFF_FFFF);
        end
    endtask

    scen_t tbl[4];
    int    nlog;

    initial begin
        tbl[0] = '{"min_lat",   0, 0,  0, 0, NWIN + Border*2*W, DB + (R-1)*W - 1};
        tbl[1] = '{"dly5_spur", 1, 5,  0, 1, NWIN + Border*2*W, DB + (R-1)*W - 1};
        tbl[2] = '{"res_held",  1, 0,  0, 2, NWIN + Border*2*W, DB + (R-1)*W - 1};
        tbl[3] = '{"rand_dly",  1, -1, 4, 1, NWIN + Border*2*W, DB + (R-1)*W - 1};

        reset = 1'b1; start = 1'b0;
        cfg_dly = 0; cfg_dmax = 0; cfg_spur = 0; win_k = 0; dly_sum = 0;
        target_k = -1; target_hit = 0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check("idle_quiet", {en, finish}, 0);

        for (int i = 0; i < 4; i++) run_scan(tbl[i]);

        // Abort mid-scan during WAIT of word (y=3, x=5)
        setup(tbl[1]);
        target_k = 2 * W + 5;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < BUDGET && !target_hit; i++) @(negedge clk);
        check("abort_target_reached", target_hit, 1);
        @(negedge clk);
        reset = 1'b1;
        #1 check_reset_outputs("abort");
        nlog = log_q.size();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("abort_no_access", log_q.size(), nlog);
        check_reset_outputs("abort_idle");
        run_scan(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
